// File: rtl/pooling_window_scheduler_if.sv
// Stream/bus bundle of the pooling window scheduler.
//   master : the scheduler (accepts pixels, drives buffer ports and result handshake)
//   slave  : the environment (layer2 stream, line buffer, pooling datapath)
interface pooling_window_scheduler_if #(
  parameter int BUF_AW = 6,
  parameter int OUT_AW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;
  logic              rd_en;
  logic [BUF_AW-1:0] rd_addr;
  logic [1:0]        rd_sel;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_AW-1:0] out_addr;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_addr, rd_en, rd_addr, rd_sel, out_valid, out_addr
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_addr, rd_en, rd_addr, rd_sel, out_valid, out_addr
  );
endinterface

// File: rtl/pooling_window_scheduler.sv
// Pooling window scheduler: writes a FMAP_H x FMAP_W pixel stream into a
// 4-row double-banked line buffer and, for every completed 2x2 window,
// issues four element reads followed by a valid/ready result slot.
// Optional feature: define POOL_STALL_CNT_EN to add the saturating
// stall_cnt[15:0] output counting cycles where a pixel is offered but refused.
module pooling_window_scheduler #(
  parameter int FMAP_W = 14,
  parameter int FMAP_H = 14,
  parameter int BUF_AW = 6,
  parameter int OUT_AW = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  pooling_window_scheduler_if.master bus,
  output logic busy,
  output logic done
`ifdef POOL_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int NW     = FMAP_W * FMAP_H / 4;
  localparam int HALF_W = FMAP_W / 2;
  localparam int RW     = $clog2(FMAP_H + 1);
  localparam int CW     = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int NWW    = $clog2(NW + 1);
  localparam int PCW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_EMIT
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;          // write row, reaches FMAP_H at frame end
  logic [CW-1:0]     col_q, col_d;
  logic [NWW-1:0]    ready_cnt_q, ready_cnt_d;
  logic [NWW-1:0]    srv_cnt_q, srv_cnt_d;  // also the raster index of the served window
  logic [RW-1:0]     pr_q, pr_d;            // row pair of the next unserved window
  logic [PCW-1:0]    pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [BUF_AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
`ifdef POOL_STALL_CNT_EN
  logic [15:0]       stall_q, stall_d;
`endif

  logic              in_ready_c;
  logic              accept;
  logic              win_ready;
  logic              start_ok;
  logic [BUF_AW-1:0] wr_addr_c;
  logic [BUF_AW-1:0] rd_base;
  logic [BUF_AW-1:0] col_off;

  // Flow control and write address: only the pair being served and the one
  // after it may be written, so a bank is never refilled before it is read.
  always_comb begin
    in_ready_c = busy_q && (row_q < RW'(FMAP_H)) && ((row_q >> 1) < (pr_q + RW'(2)));
    accept     = bus.in_valid && in_ready_c;
    win_ready  = accept && row_q[0] && col_q[0];
    start_ok   = start && !busy_q;
    wr_addr_c  = (row_q[1] ? BUF_AW'(2 * FMAP_W) : '0)
               + (row_q[0] ? BUF_AW'(FMAP_W) : '0)
               + BUF_AW'(col_q);
  end

  // Next-state logic: write counters, read sequencer and registered read port.
  // NOTE: every _d gets a default first, so no path leaves a value unassigned
  // and no latch is inferred; combinational blocks use blocking '='.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    ready_cnt_d = ready_cnt_q;
    srv_cnt_d   = srv_cnt_q;
    pr_d        = pr_q;
    pc_d        = pc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_sel_d    = 2'd0;
    rd_addr_d   = '0;
    rd_base     = '0;
    col_off     = '0;

    if (accept) begin
      if (col_q == CW'(FMAP_W - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (win_ready) ready_cnt_d = ready_cnt_q + NWW'(1);

    case (state_q)
      S_IDLE: if (srv_cnt_q < ready_cnt_q) state_d = S_RD0;
      S_RD0:  state_d = S_RD1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_RD3;
      S_RD3:  state_d = S_WAIT;
      S_WAIT: state_d = S_EMIT;
      S_EMIT: begin
        if (bus.out_ready) begin
          srv_cnt_d = srv_cnt_q + NWW'(1);
          if (pc_q == PCW'(HALF_W - 1)) begin
            pc_d = '0;
            pr_d = pr_q + RW'(1);
          end else begin
            pc_d = pc_q + PCW'(1);
          end
          if (srv_cnt_q == NWW'(NW - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (srv_cnt_d < ready_cnt_q) begin
            state_d = S_RD0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok) begin
      busy_d      = 1'b1;
      row_d       = '0;
      col_d       = '0;
      ready_cnt_d = '0;
      srv_cnt_d   = '0;
      pr_d        = '0;
      pc_d        = '0;
      state_d     = S_IDLE;
    end

    // Read port is registered: it reflects the state being entered.
    rd_base = pr_d[0] ? BUF_AW'(2 * FMAP_W) : '0;
    col_off = BUF_AW'({pc_d, 1'b0});
    case (state_d)
      S_RD0: begin rd_en_d = 1'b1; rd_sel_d = 2'd0; rd_addr_d = rd_base + col_off; end
      S_RD1: begin rd_en_d = 1'b1; rd_sel_d = 2'd1; rd_addr_d = rd_base + col_off + BUF_AW'(1); end
      S_RD2: begin rd_en_d = 1'b1; rd_sel_d = 2'd2; rd_addr_d = rd_base + col_off + BUF_AW'(FMAP_W); end
      S_RD3: begin rd_en_d = 1'b1; rd_sel_d = 2'd3; rd_addr_d = rd_base + col_off + BUF_AW'(FMAP_W + 1); end
      default: ;
    endcase
  end

`ifdef POOL_STALL_CNT_EN
  // Saturating count of cycles where a pixel is offered during a frame but refused.
  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (bus.in_valid && busy_q && !in_ready_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  // State register with synchronous reset.
  // NOTE: rst_n is sampled on the clock edge (synchronous), and all state
  // uses non-blocking '<=' so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ready_cnt_q <= '0;
      srv_cnt_q   <= '0;
      pr_q        <= '0;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_sel_q    <= 2'd0;
`ifdef POOL_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ready_cnt_q <= ready_cnt_d;
      srv_cnt_q   <= srv_cnt_d;
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_sel_q    <= rd_sel_d;
`ifdef POOL_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wr_en     = accept;
  assign bus.wr_addr   = wr_addr_c;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_sel    = rd_sel_q;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_addr  = OUT_AW'(srv_cnt_q);
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef POOL_STALL_CNT_EN
  assign stall_cnt     = stall_q;
`endif

endmodule
